// File: rtl/mem_burst_tester_if.sv
// Burst bus between the DDR traffic generator (master) and the AXI burst bridge (slave).
// A request level stays high, with its address stable, until the matching one-cycle finish pulse;
// a data strobe (wr_burst_data_req / rd_burst_data_valid) moves exactly one beat in the cycle it is high.
interface mem_burst_tester_if;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [31:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [63:0] wr_burst_data;
  logic        wr_burst_finish;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [31:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic [63:0] rd_burst_data;
  logic        rd_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );
endinterface

// File: rtl/mem_burst_tester.sv
// DDR traffic generator: sweeps a region with pattern write bursts, reads it back and
// checks every beat, keeping a sticky error flag and a count of completed sweeps.
module mem_burst_tester #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 27,
  parameter int BURST_LEN     = 128,
  parameter int ADDR_LIMIT    = 4096
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [31:0]        start,
  mem_burst_tester_if.master bus,
  output logic               error,
  output logic [15:0]        pass_count,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  localparam logic [9:0]         BURST_BEATS = 10'(BURST_LEN);
  localparam logic [ADDR_BITS:0] BURST_STEP  = (ADDR_BITS + 1)'(BURST_LEN);
  localparam logic [ADDR_BITS:0] SWEEP_END   = (ADDR_BITS + 1)'(ADDR_LIMIT);

  logic [1:0]           state;
  logic                 start_r, start_d, armed;
  logic                 wr_req, rd_req;
  logic [ADDR_BITS-1:0] base;
  logic [9:0]           wbeat, rbeat;
  logic [31:0]          seed;

  logic                     unused_start;
  logic                     rise;
  logic [ADDR_BITS:0]       base_sum;
  logic                     sweep_done;
  logic [ADDR_BITS-1:0]     next_base;
  logic [MEM_DATA_BITS-1:0] wr_word, rd_expect;
  logic                     rd_beat_ok;
  logic [9:0]               rbeat_final;

  function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [ADDR_BITS-1:0] a,
                                                        input logic [31:0] s);
    logic [31:0] v;
    v = 32'(a) + s;
    return {v, ~v};
  endfunction

  assign unused_start = ^start[31:1];

  // A run only starts on a 0->1 of start[0] actually observed after reset, so a level
  // held high through reset does not launch a sweep.
  assign rise = start_r & ~start_d & armed;

  // One extra bit so a sweep ending exactly at 2^ADDR_BITS is still detected.
  assign base_sum   = {1'b0, base} + BURST_STEP;
  assign sweep_done = (base_sum == SWEEP_END);
  assign next_base  = sweep_done ? '0 : base_sum[ADDR_BITS-1:0];

  assign wr_word     = pattern(base + ADDR_BITS'(wbeat), seed);
  assign rd_expect   = pattern(base + ADDR_BITS'(rbeat), seed);
  assign rd_beat_ok  = bus.rd_burst_data_valid && (rbeat < BURST_BEATS);
  assign rbeat_final = rbeat + {9'd0, rd_beat_ok};

  assign bus.wr_burst_req  = wr_req;
  assign bus.wr_burst_len  = BURST_BEATS;
  assign bus.wr_burst_addr = 32'(base);
  assign bus.wr_burst_data = wr_req ? wr_word : '0;
  assign bus.rd_burst_req  = rd_req;
  assign bus.rd_burst_len  = BURST_BEATS;
  assign bus.rd_burst_addr = 32'(base);

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= S_IDLE;
      start_r    <= 1'b0;
      start_d    <= 1'b0;
      armed      <= 1'b0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      base       <= '0;
      wbeat      <= '0;
      rbeat      <= '0;
      seed       <= '0;
      error      <= 1'b0;
      pass_count <= '0;
    end else begin
      start_r <= start[0];
      start_d <= start_r;
      armed   <= armed | ~start[0];
      case (state)
        S_IDLE: begin
          if (rise) begin
            error      <= 1'b0;
            pass_count <= '0;
            seed       <= '0;
            base       <= '0;
            wbeat      <= '0;
            rbeat      <= '0;
            state      <= S_WR;
          end
        end
        S_WR: begin
          // Request stays low one cycle after each finish before the next burst.
          if (!wr_req) begin
            if (!start_r) state <= S_IDLE;
            else          wr_req <= 1'b1;
          end else begin
            if (bus.wr_burst_data_req) wbeat <= wbeat + 10'd1;
            if (bus.wr_burst_finish) begin
              wr_req <= 1'b0;
              wbeat  <= '0;
              base   <= next_base;
              if (!start_r)        state <= S_IDLE;
              else if (sweep_done) state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!rd_req) begin
            if (!start_r) state <= S_IDLE;
            else          rd_req <= 1'b1;
          end else begin
            if (bus.rd_burst_data_valid) begin
              if (!rd_beat_ok) begin
                error <= 1'b1;
              end else begin
                rbeat <= rbeat + 10'd1;
                if (bus.rd_burst_data != rd_expect) error <= 1'b1;
              end
            end
            if (bus.rd_burst_finish) begin
              if (rbeat_final != BURST_BEATS) error <= 1'b1;
              rd_req <= 1'b0;
              rbeat  <= '0;
              base   <= next_base;
              if (sweep_done) begin
                pass_count <= pass_count + 16'd1;
                seed       <= seed + 32'd1;
                state      <= start_r ? S_WR : S_IDLE;
              end else if (!start_r) begin
                state <= S_IDLE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_tester.sv
// Directed bench: an ideal-memory bridge model serves the generator's bursts while a
// scoreboard queue holds the expected write beats.
module tb_mem_burst_tester;
  localparam int BL  = 4;
  localparam int LIM = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [31:0] start;
  logic        error;
  logic [15:0] pass_count;
  logic        busy;
  logic [1:0]  dbg_state;

  mem_burst_tester_if bus();

  mem_burst_tester #(
    .MEM_DATA_BITS(64),
    .ADDR_BITS(27),
    .BURST_LEN(BL),
    .ADDR_LIMIT(LIM)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .start(start),
    .bus(bus),
    .error(error),
    .pass_count(pass_count),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mem[0:LIM-1];
  logic [31:0] tb_seed;
  logic        exp_err;
  logic [15:0] exp_pass;

  function automatic logic [63:0] pat(input int unsigned a, input logic [31:0] s);
    logic [31:0] v;
    v = a + s;
    return {v, ~v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_req(input bit rd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((rd ? bus.rd_burst_req : bus.wr_burst_req) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(rd ? "rd_req_seen" : "wr_req_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic serve_write(input int exp_addr, input bit bubbles);
    bit          ok;
    logic [63:0] d;
    logic [63:0] e;
    wait_req(1'b0, ok);
    if (!ok) return;
    check("wr_addr", 64'(bus.wr_burst_addr), 64'(exp_addr));
    check("wr_len", 64'(bus.wr_burst_len), 64'(BL));
    for (int i = 0; i < BL; i++) exp_q.push_back(pat(exp_addr + i, tb_seed));
    for (int i = 0; i < BL; i++) begin
      if (bubbles && i > 0) begin
        bus.wr_burst_data_req = 1'b0;
        tick();
      end
      bus.wr_burst_data_req = 1'b1;
      d = bus.wr_burst_data;
      e = exp_q.pop_front();
      check("wr_data", d, e);
      mem[(exp_addr + i) % LIM] = d;
      tick();
    end
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.wr_burst_finish = 1'b0;
    check("wr_req_drop", {63'd0, bus.wr_burst_req}, 64'd0);
  endtask

  task automatic serve_read(input int exp_addr, input int nbeats, input int bad_addr);
    bit ok;
    wait_req(1'b1, ok);
    if (!ok) return;
    check("rd_addr", 64'(bus.rd_burst_addr), 64'(exp_addr));
    check("err_before_rd", {63'd0, error}, {63'd0, exp_err});
    for (int i = 0; i < nbeats; i++) begin
      bus.rd_burst_data_valid = 1'b1;
      bus.rd_burst_data = mem[(exp_addr + i) % LIM] ^ (((exp_addr + i) == bad_addr) ? 64'd1 : 64'd0);
      tick();
      if ((exp_addr + i) == bad_addr) begin
        exp_err = 1'b1;
        check("err_after_bad_beat", {63'd0, error}, 64'd1);
      end
    end
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data = '0;
    bus.rd_burst_finish = 1'b1;
    tick();
    bus.rd_burst_finish = 1'b0;
    if (nbeats != BL) exp_err = 1'b1;
    check("rd_req_drop", {63'd0, bus.rd_burst_req}, 64'd0);
    check("err_after_rd", {63'd0, error}, {63'd0, exp_err});
  endtask

  task automatic run_writes();
    for (int b = 0; b < LIM / BL; b++) serve_write(b * BL, (b % 2) == 1);
  endtask

  task automatic run_reads(input int bad_addr);
    for (int b = 0; b < LIM / BL; b++) serve_read(b * BL, BL, bad_addr);
    exp_pass = exp_pass + 16'd1;
    tb_seed  = tb_seed + 32'd1;
    check("pass_count", 64'(pass_count), 64'(exp_pass));
  endtask

  initial begin
    bit ok;
    start = '0;
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data = '0;
    bus.rd_burst_finish = 1'b0;
    exp_err = 1'b0;
    exp_pass = '0;
    tb_seed = '0;

    // Clock/reset
    #2 ARESETN = 1'b0;
    repeat (3) tick();
    check("rst_wr_req", {63'd0, bus.wr_burst_req}, 64'd0);
    check("rst_rd_req", {63'd0, bus.rd_burst_req}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_pass", 64'(pass_count), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_wr_data", bus.wr_burst_data, 64'd0);
    ARESETN = 1'b1;
    repeat (2) tick();
    check("idle_state", 64'(dbg_state), 64'd0);

    // Three clean-ish sweeps; the third corrupts the read beat at address 9.
    start = 32'hFFFF_FFFE | 32'd1;
    run_writes();
    check("beat5_seed0", mem[5], 64'h0000_0005_FFFF_FFFA);
    run_reads(-1);
    check("err_pass0", {63'd0, error}, 64'd0);
    run_writes();
    check("beat5_seed1", mem[5], 64'h0000_0006_FFFF_FFF9);
    run_reads(-1);
    run_writes();
    run_reads(9);
    check("err_sticky", {63'd0, error}, 64'd1);

    // Drop start during the second write burst of the next sweep.
    serve_write(0, 1'b0);
    wait_req(1'b0, ok);
    start = 32'd0;
    serve_write(4, 1'b0);
    tick();
    check("busy_after_drop", {63'd0, busy}, 64'd0);
    repeat (10) tick();
    check("no_wr_req_idle", {63'd0, bus.wr_burst_req}, 64'd0);
    check("no_rd_req_idle", {63'd0, bus.rd_burst_req}, 64'd0);
    check("err_kept_idle", {63'd0, error}, 64'd1);
    check("pass_kept_idle", 64'(pass_count), 64'(exp_pass));

    // Restart clears error and pass_count, then a read burst comes back short.
    start = 32'd1;
    repeat (3) tick();
    exp_err = 1'b0;
    exp_pass = '0;
    tb_seed = '0;
    check("restart_err", {63'd0, error}, 64'd0);
    check("restart_pass", 64'(pass_count), 64'd0);
    check("restart_busy", {63'd0, busy}, 64'd1);
    run_writes();
    serve_read(0, 3, -1);

    // Asynchronous reset while a read request is pending.
    wait_req(1'b1, ok);
    ARESETN = 1'b0;
    #1;
    check("arst_rd_req", {63'd0, bus.rd_burst_req}, 64'd0);
    check("arst_error", {63'd0, error}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_rd_addr", 64'(bus.rd_burst_addr), 64'd0);
    check("arst_pass", 64'(pass_count), 64'd0);
    tick();
    ARESETN = 1'b1;
    tick();
    // Stray strobes in IDLE must be ignored.
    bus.rd_burst_data_valid = 1'b1;
    bus.rd_burst_data = {$urandom, $urandom};
    bus.rd_burst_finish = 1'b1;
    bus.wr_burst_data_req = 1'b1;
    bus.wr_burst_finish = 1'b1;
    tick();
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_data = '0;
    bus.rd_burst_finish = 1'b0;
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish = 1'b0;
    repeat ($urandom_range(8, 12)) tick();
    check("held_start_busy", {63'd0, busy}, 64'd0);
    check("held_start_wr_req", {63'd0, bus.wr_burst_req}, 64'd0);
    check("stray_strobe_err", {63'd0, error}, 64'd0);

    // A fresh 0->1 of start launches a new sweep from seed 0.
    start = 32'd0;
    repeat (2) tick();
    start = 32'd1;
    exp_err = 1'b0;
    tb_seed = '0;
    serve_write(0, 1'b0);
    check("rerun_busy", {63'd0, busy}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
